regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the 16 x 32-bit register file. Several writeback sources (ALU, load unit, vector/scalar move) share the register file's single write port through a round-robin request/ready handshake. A per-register busy scoreboard lets decode stall on pending destinations, and a drain FSM quiesces all outstanding writes before a context switch. Register 9 is externally driven (r9 input of the register file), so writes to it are discarded.

---
 rtl/regfile_wb_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter, busy scoreboard and drain FSM for the 16 x 32 register file.
// Define WB_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int EXT_REG = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      writeEnable,
    output logic [ADDR_W-1:0]         writeAddr,
    output logic [DATA_W-1:0]         writeData,
    input  logic                      reserve_valid,
    input  logic [ADDR_W-1:0]         reserve_addr,
    output logic                      reserve_ready,
    output logic [(2**ADDR_W)-1:0]    busy,
    input  logic                      drain_req,
    output logic                      drain_done
);

    localparam int                NREG     = 2**ADDR_W;
    localparam int                PTR_W    = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] EXT_ADDR = ADDR_W'(EXT_REG);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    gnt_idx;
    logic                xfer;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_data;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NREG-1:0]     busy_q, busy_d;

`ifdef WB_ARB_FIXED_PRIO_EN
    always_comb begin
        logic found;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gnt_idx  = PTR_W'(i);
            end
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    // Scan cyclically starting at rr_ptr; first valid requester wins.
    always_comb begin
        logic found;
        int   idx;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign req_ready = rst_n ? grant : '0;
    assign xfer      = |req_ready;
    assign gnt_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign gnt_data  = req_data[gnt_idx*DATA_W +: DATA_W];

    // Writes to the externally driven register are accepted but never reach the regfile.
    assign we_d = xfer && (gnt_addr != EXT_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= we_d;
            if (we_d) begin
                waddr_q <= gnt_addr;
                wdata_q <= gnt_data;
            end
        end
    end

    // Set is applied after clear so a same-cycle reservation wins.
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[gnt_addr] = 1'b0;
        end
        if (reserve_valid && reserve_ready && (reserve_addr != EXT_ADDR)) begin
            busy_d[reserve_addr] = 1'b1;
        end
        busy_d[EXT_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // DONE is entered on the edge after which busy and writeEnable both read zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!drain_req) begin
                    state_d = RUN;
                end else if ((busy_d == '0) && !we_d) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!drain_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign reserve_ready = (state_q == RUN);
    assign drain_done    = (state_q == DONE);
    assign writeEnable   = we_q;
    assign writeAddr     = waddr_q;
    assign writeData     = wdata_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, arbitration order,
// EXT_REG discard, scoreboard collision and drain sequencing.
module tb_regfile_wb_arbiter;

    logic         clk;
    logic         rst_n;
    logic [2:0]   req_valid;
    logic [11:0]  req_addr;
    logic [95:0]  req_data;
    logic [2:0]   req_ready;
    logic         writeEnable;
    logic [3:0]   writeAddr;
    logic [31:0]  writeData;
    logic         reserve_valid;
    logic [3:0]   reserve_addr;
    logic         reserve_ready;
    logic [15:0]  busy;
    logic         drain_req;
    logic         drain_done;

    int vec_cnt = 0;
    int err_cnt = 0;

    regfile_wb_arbiter #(
        .NUM_REQ(3), .DATA_W(32), .ADDR_W(4), .EXT_REG(9)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
        .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
        .reserve_ready(reserve_ready), .busy(busy),
        .drain_req(drain_req), .drain_done(drain_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [31:0] d);
        req_addr[i*4 +: 4]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic test_reset;
        reserve_valid = 1'b1; reserve_addr = 4'd2;
        tick;
        reserve_valid = 1'b0;
        set_req(0, 4'd7, 32'hDEADBEEF);
        req_valid = 3'b001;
        tick;
        req_valid = 3'b000;
        vec_cnt++; if (busy[2] !== 1'b1) begin err_cnt++; $display("FAIL pre_rst_busy2 got=%b exp=1", busy[2]); end
        vec_cnt++; if (writeEnable !== 1'b1) begin err_cnt++; $display("FAIL pre_rst_we got=%b exp=1", writeEnable); end
        #2;
        req_valid = 3'b111;
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (writeEnable !== 1'b0) begin err_cnt++; $display("FAIL rst_we got=%b exp=0", writeEnable); end
        vec_cnt++; if (writeAddr !== 4'd0) begin err_cnt++; $display("FAIL rst_waddr got=%h exp=0", writeAddr); end
        vec_cnt++; if (writeData !== 32'd0) begin err_cnt++; $display("FAIL rst_wdata got=%h exp=0", writeData); end
        vec_cnt++; if (busy !== 16'h0000) begin err_cnt++; $display("FAIL rst_busy got=%h exp=0000", busy); end
        vec_cnt++; if (req_ready !== 3'b000) begin err_cnt++; $display("FAIL rst_ready got=%b exp=000", req_ready); end
        vec_cnt++; if (drain_done !== 1'b0) begin err_cnt++; $display("FAIL rst_drain_done got=%b exp=0", drain_done); end
        vec_cnt++; if (reserve_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_reserve_ready got=%b exp=1", reserve_ready); end
        req_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single_write;
        set_req(0, 4'd2, 32'hA5A5A5A5);
        req_valid = 3'b001;
        @(negedge clk);
        vec_cnt++; if (req_ready !== 3'b001) begin err_cnt++; $display("FAIL single_ready got=%b exp=001", req_ready); end
        tick;
        req_valid = 3'b000;
        vec_cnt++; if (writeEnable !== 1'b1) begin err_cnt++; $display("FAIL single_we_n1 got=%b exp=1", writeEnable); end
        vec_cnt++; if (writeAddr !== 4'd2) begin err_cnt++; $display("FAIL single_waddr got=%h exp=2", writeAddr); end
        vec_cnt++; if (writeData !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL single_wdata got=%h exp=a5a5a5a5", writeData); end
        tick;
        vec_cnt++; if (writeEnable !== 1'b0) begin err_cnt++; $display("FAIL single_we_n2 got=%b exp=0", writeEnable); end
        vec_cnt++; if (writeAddr !== 4'd2) begin err_cnt++; $display("FAIL single_waddr_hold got=%h exp=2", writeAddr); end
    endtask

    task automatic test_round_robin;
        logic [3:0]  rr_addr [3];
        logic [31:0] rr_data [3];
        logic [2:0]  exp_rdy;
        int          exp;
        rr_addr[0] = 4'd4; rr_addr[1] = 4'd6; rr_addr[2] = 4'd8;
        rr_data[0] = 32'h11111111; rr_data[1] = 32'h22222222; rr_data[2] = 32'h33333333;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, rr_addr[i], rr_data[i]);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            exp = 0;
`else
            exp = k % 3;
`endif
            exp_rdy = 3'b001 << exp;
            @(negedge clk);
            vec_cnt++; if (req_ready !== exp_rdy) begin err_cnt++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, exp_rdy); end
            tick;
            vec_cnt++; if ({writeEnable, writeAddr, writeData} !== {1'b1, rr_addr[exp], rr_data[exp]})
                begin err_cnt++; $display("FAIL rr_write[%0d] got=%b/%h/%h exp=1/%h/%h", k, writeEnable, writeAddr, writeData, rr_addr[exp], rr_data[exp]); end
        end
        req_valid = 3'b000;
        tick;
    endtask

    task automatic test_ext_reg;
        set_req(1, 4'd9, 32'h12345678);
        req_valid = 3'b010;
        @(negedge clk);
        vec_cnt++; if (req_ready !== 3'b010) begin err_cnt++; $display("FAIL ext_ready got=%b exp=010", req_ready); end
        tick;
        req_valid = 3'b000;
        vec_cnt++; if (writeEnable !== 1'b0) begin err_cnt++; $display("FAIL ext_we got=%b exp=0", writeEnable); end
        reserve_valid = 1'b1; reserve_addr = 4'd9;
        tick;
        reserve_valid = 1'b0;
        vec_cnt++; if (busy !== 16'h0000) begin err_cnt++; $display("FAIL ext_busy got=%h exp=0000", busy); end
    endtask

    task automatic test_collision;
        reserve_valid = 1'b1; reserve_addr = 4'd5;
        tick;
        vec_cnt++; if (busy !== 16'h0020) begin err_cnt++; $display("FAIL coll_reserve got=%h exp=0020", busy); end
        set_req(0, 4'd5, 32'h55555555);
        req_valid = 3'b001;
        @(negedge clk);
        vec_cnt++; if (req_ready !== 3'b001) begin err_cnt++; $display("FAIL coll_ready got=%b exp=001", req_ready); end
        tick;
        reserve_valid = 1'b0;
        vec_cnt++; if (busy !== 16'h0020) begin err_cnt++; $display("FAIL coll_set_wins got=%h exp=0020", busy); end
        vec_cnt++; if ({writeEnable, writeAddr} !== {1'b1, 4'd5}) begin err_cnt++; $display("FAIL coll_write got=%b/%h exp=1/5", writeEnable, writeAddr); end
        tick;
        req_valid = 3'b000;
        vec_cnt++; if (busy !== 16'h0000) begin err_cnt++; $display("FAIL coll_clear got=%h exp=0000", busy); end
        tick;
    endtask

    task automatic test_drain_abort;
        reserve_valid = 1'b1; reserve_addr = 4'd6;
        tick;
        reserve_valid = 1'b0;
        drain_req = 1'b1;
        tick;
        vec_cnt++; if ({reserve_ready, drain_done} !== 2'b00) begin err_cnt++; $display("FAIL abort_drain got=%b exp=00", {reserve_ready, drain_done}); end
        drain_req = 1'b0;
        tick;
        vec_cnt++; if ({reserve_ready, drain_done} !== 2'b10) begin err_cnt++; $display("FAIL abort_run got=%b exp=10", {reserve_ready, drain_done}); end
        set_req(0, 4'd6, 32'h66666666);
        req_valid = 3'b001;
        tick;
        req_valid = 3'b000;
        vec_cnt++; if (busy !== 16'h0000) begin err_cnt++; $display("FAIL abort_clear got=%h exp=0000", busy); end
        tick;
    endtask

    task automatic test_drain;
        reserve_valid = 1'b1; reserve_addr = 4'd3;
        tick;
        reserve_valid = 1'b0;
        vec_cnt++; if (busy !== 16'h0008) begin err_cnt++; $display("FAIL drain_busy3 got=%h exp=0008", busy); end
        drain_req = 1'b1;
        tick;
        vec_cnt++; if (reserve_ready !== 1'b0) begin err_cnt++; $display("FAIL drain_resv_rdy got=%b exp=0", reserve_ready); end
        reserve_valid = 1'b1; reserve_addr = 4'd4;
        tick;
        reserve_valid = 1'b0;
        vec_cnt++; if (busy !== 16'h0008) begin err_cnt++; $display("FAIL drain_resv_blocked got=%h exp=0008", busy); end
        vec_cnt++; if (drain_done !== 1'b0) begin err_cnt++; $display("FAIL drain_busy_wait got=%b exp=0", drain_done); end
        set_req(2, 4'd3, 32'hC0FFEE00);
        req_valid = 3'b100;
        @(negedge clk);
        vec_cnt++; if (req_ready !== 3'b100) begin err_cnt++; $display("FAIL drain_ready got=%b exp=100", req_ready); end
        tick;
        req_valid = 3'b000;
        vec_cnt++; if ({writeEnable, writeAddr, busy} !== {1'b1, 4'd3, 16'h0000}) begin err_cnt++; $display("FAIL drain_write got=%b/%h/%h exp=1/3/0000", writeEnable, writeAddr, busy); end
        vec_cnt++; if (drain_done !== 1'b0) begin err_cnt++; $display("FAIL drain_we_cycle got=%b exp=0", drain_done); end
        tick;
        vec_cnt++; if ({writeEnable, drain_done, reserve_ready} !== 3'b010) begin err_cnt++; $display("FAIL drain_done got=%b exp=010", {writeEnable, drain_done, reserve_ready}); end
        drain_req = 1'b0;
        tick;
        vec_cnt++; if ({drain_done, reserve_ready} !== 2'b01) begin err_cnt++; $display("FAIL drain_back_run got=%b exp=01", {drain_done, reserve_ready}); end
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        req_addr      = '0;
        req_data      = '0;
        reserve_valid = 1'b0;
        reserve_addr  = '0;
        drain_req     = 1'b0;
        #12;
        rst_n = 1'b1;
        tick;
        test_reset;
        test_single_write;
        test_round_robin;
        test_ext_reg;
        test_collision;
        test_drain_abort;
        test_drain;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
